// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: FIFO controller wrapped around a single-port RAM.
// Writes from a valid/ready stream go into the RAM. Reads are prefetched into a
// registered output stage. The single RAM port serves at most one access per
// cycle, and prefetch reads take priority over writes.
// RD_LATENCY = 0 suits async-read (distributed) RAM.
// RD_LATENCY = 1 suits sync-read (block) RAM.
// Optional feature: define SPRAM_FIFO_BYPASS_EN to let a write go straight into
// the output register when the FIFO is otherwise empty.
module spram_fifo_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH:0]   count
);

    localparam bit SYNC_READ = (RD_LATENCY == 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  inflight;

    logic                  pf_req;
    logic                  accept;
    logic                  pop;
    logic                  byp_take;
    logic                  to_ram;
    logic                  capture;
    logic [DATA_WIDTH-1:0] cap_data;

    // Port arbitration, handshakes, and selection of the word that loads the output register
    always_comb begin
        pf_req   = (ram_cnt != '0) && !inflight && (!m_valid || m_ready);
        s_ready  = !rst && !ram_cnt[ADDR_WIDTH] && !pf_req;
        accept   = s_valid && s_ready;
        pop      = m_valid && m_ready;
`ifdef SPRAM_FIFO_BYPASS_EN
        byp_take = accept && (ram_cnt == '0) && !inflight && (!m_valid || m_ready);
`else
        byp_take = 1'b0;
`endif
        to_ram   = accept && !byp_take;
        ram_we   = to_ram;
        ram_addr = pf_req ? rd_ptr : wr_ptr;
        ram_din  = s_data;
        capture  = SYNC_READ ? inflight : pf_req;
        cap_data = byp_take ? s_data : ram_dout;
    end

    // Pointer, occupancy, in-flight and output-register state; reset drops everything including pending reads
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            count    <= '0;
        end else begin
            if (to_ram) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pf_req) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({to_ram, pf_req})
                2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                default: ram_cnt <= ram_cnt;
            endcase
            inflight <= SYNC_READ && pf_req;
            if (capture || byp_take) begin
                m_data  <= cap_data;
                m_valid <= 1'b1;
            end else if (pop) begin
                m_valid <= 1'b0;
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
